// File: rtl/iob_sync_pack_fifo_pkg.sv
// Shared definitions for the narrow-in / wide-out packing FIFO.
// RATIO, LANE_W and DEPTH are provided as localparams for the default build.
// Helper functions derive the same values for any legal parameter set.
// Further helpers validate the parameters and count the stored lanes.
package iob_sync_pack_fifo_pkg;

  localparam int unsigned DEF_W_DATA_W = 8;
  localparam int unsigned DEF_R_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W   = 4;

  function automatic int unsigned calc_ratio(input int unsigned r_w, input int unsigned w_w);
    return r_w / w_w;
  endfunction

  function automatic int unsigned calc_lane_w(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

  function automatic int unsigned calc_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  localparam int unsigned RATIO  = calc_ratio(DEF_R_DATA_W, DEF_W_DATA_W);
  localparam int unsigned LANE_W = calc_lane_w(RATIO);
  localparam int unsigned DEPTH  = calc_depth(DEF_ADDR_W);

  // R must be an exact power-of-two multiple (>= 2) of W.
  function automatic bit params_ok(input int unsigned r_w, input int unsigned w_w,
                                   input int unsigned addr_w);
    int unsigned ratio;
    if (w_w == 0 || addr_w == 0) return 1'b0;
    if ((r_w % w_w) != 0) return 1'b0;
    ratio = r_w / w_w;
    return (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
  endfunction

  // Lanes held by a pushed word: lanes already packed plus one if a write
  // lands in the same cycle.
  function automatic int unsigned stored_lanes(input int unsigned lane_cnt, input bit wr_acc);
    return lane_cnt + (wr_acc ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/iob_pack_fifo_mem.sv
// Two-port register array for the packing FIFO.
// The write port is synchronous. The read port is registered and updates
// only while rd_en_i is high.
// Ports: clk_i, rst_n_i (async, active low; clears only the read register),
//        wr_en_i/wr_addr_i/wr_data_i, rd_en_i/rd_addr_i, rd_data_o.
module iob_pack_fifo_mem #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 35
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/iob_sync_pack_fifo.sv
// Single-clock FIFO that packs RATIO narrow writes into one wide read word.
// A flush request pushes a partially filled word early. Each stored word
// carries a lanes field that gives the number of valid lanes.
// Ports: clk, rst (async, active low), data_in/write_en/full,
//        flush/flush_ack, read_en/data_out/data_out_lanes, empty, level.
module iob_sync_pack_fifo
  import iob_sync_pack_fifo_pkg::*;
#(
  parameter int unsigned W_DATA_W = 8,
  parameter int unsigned R_DATA_W = 32,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [W_DATA_W-1:0]                                data_in,
  input  logic                                               write_en,
  output logic                                               full,
  input  logic                                               flush,
  output logic                                               flush_ack,
  input  logic                                               read_en,
  output logic [R_DATA_W-1:0]                                data_out,
  output logic [calc_lane_w(calc_ratio(R_DATA_W, W_DATA_W))-1:0] data_out_lanes,
  output logic                                               empty,
  output logic [ADDR_W:0]                                    level
);

  localparam int unsigned RAT   = calc_ratio(R_DATA_W, W_DATA_W);
  localparam int unsigned LW    = calc_lane_w(RAT);
  localparam int unsigned DEP   = calc_depth(ADDR_W);
  localparam int unsigned CNT_W = $clog2(RAT);
  localparam int unsigned ENT_W = R_DATA_W + LW;

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RAT - 1);
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEP);

  if (!params_ok(R_DATA_W, W_DATA_W, ADDR_W)) begin : g_bad_params
    $error("iob_sync_pack_fifo: R_DATA_W must be W_DATA_W * 2**k with k >= 1");
  end

  logic [CNT_W-1:0]    lane_cnt_q, lane_cnt_d;
  logic [R_DATA_W-1:0] pack_q, pack_d;
  logic [ADDR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]     level_q, level_d;
  logic                flush_ack_q, flush_ack_d;

  logic                room, last_lane, full_c, empty_c;
  logic                wr_acc, rd_acc, word_push, flush_push, push;
  logic [R_DATA_W-1:0] merged;
  logic [LW-1:0]       push_lanes;
  logic [ENT_W-1:0]    rd_word;

  // Status comes only from registered state; read and write requests never
  // reach these signals combinationally.
  assign room      = (level_q != DEPTH_L);
  assign last_lane = (lane_cnt_q == LAST_LANE);
  assign full_c    = ~room & last_lane;
  assign empty_c   = (level_q == '0);

  assign wr_acc = write_en & ~full_c;
  assign rd_acc = read_en & ~empty_c;

  // The packing register with the current write merged into its lane.
  // Lanes above the write are already zero because the register clears on
  // every push.
  always_comb begin
    merged = pack_q;
    for (int unsigned i = 0; i < RAT; i++) begin
      if (wr_acc && (lane_cnt_q == CNT_W'(i))) merged[i*W_DATA_W +: W_DATA_W] = data_in;
    end
  end

  // A completing write always has room, because full_c would otherwise block it.
  // A flush pushes only when there is something to push and room to push it.
  assign word_push  = wr_acc & last_lane;
  assign flush_push = flush & room & ~word_push & ((lane_cnt_q != '0) | wr_acc);
  assign push       = word_push | flush_push;
  assign push_lanes = LW'(stored_lanes(32'(lane_cnt_q), wr_acc));

  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    pack_d      = pack_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    flush_ack_d = flush & (((lane_cnt_q == '0) & ~wr_acc) | push);

    if (push) begin
      lane_cnt_d = '0;
      pack_d     = '0;
      wptr_d     = wptr_q + ADDR_W'(1);
    end else if (wr_acc) begin
      lane_cnt_d = lane_cnt_q + CNT_W'(1);
      pack_d     = merged;
    end

    if (rd_acc) rptr_d = rptr_q + ADDR_W'(1);

    case ({push, rd_acc})
      2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt_q  <= '0;
      pack_q      <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      flush_ack_q <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      pack_q      <= pack_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      flush_ack_q <= flush_ack_d;
    end
  end

  iob_pack_fifo_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (ENT_W)
  ) u_mem (
    .clk_i     (clk),
    .rst_n_i   (rst),
    .wr_en_i   (push),
    .wr_addr_i (wptr_q),
    .wr_data_i ({push_lanes, merged}),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rptr_q),
    .rd_data_o (rd_word)
  );

  assign data_out       = rd_word[R_DATA_W-1:0];
  assign data_out_lanes = rd_word[R_DATA_W +: LW];
  assign full           = full_c;
  assign empty          = empty_c;
  assign level          = level_q;
  assign flush_ack      = flush_ack_q;

endmodule
